i2s_apb_master: RTL and testbench



---
 rtl/ctrl_pkg.sv | 20 ++
 rtl/apb_poll_timer.sv | 34 +++
 rtl/i2s_apb_master.sv | 186 ++++++++++++++++++
 tb/tb_i2s_apb_master.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared register map and state encodings for the I2S APB master.
package ctrl_pkg;

  localparam logic [31:0] TX_ADDR   = 32'h0000_0000;
  localparam logic [31:0] CTRL_ADDR = 32'h0000_0004;
  localparam logic [31:0] RX_ADDR   = 32'h0000_0008;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } apb_state_e;

  typedef enum logic [1:0] {
    XF_TX,
    XF_CFG,
    XF_RX
  } xfer_e;

endpackage

// File: rtl/apb_poll_timer.sv
// Free-running RX poll divider: raises rx_due every POLL_DIV cycles while enabled.
module apb_poll_timer #(
  parameter int unsigned POLL_DIV = 64
) (
  input  logic pclk,
  input  logic rst_,
  input  logic en,
  input  logic clr,
  output logic rx_due
);

  localparam int unsigned CW = $clog2(POLL_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(POLL_DIV - 1);

  logic [CW-1:0] cnt;

  // A wrap coinciding with clr keeps rx_due set: a fresh poll interval has elapsed.
  always_ff @(posedge pclk or negedge rst_) begin
    if (!rst_) begin
      cnt    <= '0;
      rx_due <= 1'b0;
    end else if (!en) begin
      cnt    <= '0;
      rx_due <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt    <= '0;
      rx_due <= 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
      if (clr) rx_due <= 1'b0;
    end
  end

endmodule

// File: rtl/i2s_apb_master.sv
// APB master moving TX samples, control writes and polled RX reads to an I2S peripheral.
module i2s_apb_master
  import ctrl_pkg::*;
#(
  parameter int unsigned POLL_DIV = 64,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        pclk,
  input  logic        rst_,
  input  logic        cfg_req,
  input  logic [31:0] cfg_ctrl,
  output logic        cfg_busy,
  input  logic        rx_en,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr,
  output logic        err
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  rst_sync;
  logic        run;
  apb_state_e  state, state_nxt;
  xfer_e       cur, grant_kind;
  logic        grant, xfer_done, xfer_to, xfer_fin;
  logic [7:0]  acnt;
  logic        cfg_pend;
  logic [31:0] cfg_data;
  logic        tx_full;
  logic [31:0] tx_data;
  logic        rx_due, rx_clr;

  // Release is synchronised so the first grant never races reset deassertion.
  always_ff @(posedge pclk or negedge rst_) begin
    if (!rst_) rst_sync <= '0;
    else       rst_sync <= {rst_sync[0], 1'b1};
  end
  assign run = rst_sync[1];

  apb_poll_timer #(
    .POLL_DIV(POLL_DIV)
  ) u_poll (
    .pclk  (pclk),
    .rst_  (rst_),
    .en    (rx_en),
    .clr   (rx_clr),
    .rx_due(rx_due)
  );

  always_ff @(posedge pclk or negedge rst_) begin
    if (!rst_) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    grant_kind = XF_TX;
    xfer_done  = 1'b0;
    xfer_to    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (run) begin
          if (cfg_pend) begin
            grant      = 1'b1;
            grant_kind = XF_CFG;
          end else if (rx_due && !m_valid) begin
            grant      = 1'b1;
            grant_kind = XF_RX;
          end else if (tx_full) begin
            grant      = 1'b1;
            grant_kind = XF_TX;
          end
        end
        if (grant) state_nxt = ST_SETUP;
      end
      ST_SETUP: state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (pready) begin
          xfer_done = 1'b1;
          state_nxt = ST_IDLE;
        end else if (acnt == TO_LAST) begin
          xfer_to   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign xfer_fin = xfer_done | xfer_to;
  assign psel     = (state != ST_IDLE);
  assign penable  = (state == ST_ACCESS);
  assign rx_clr   = xfer_fin && (cur == XF_RX);
  assign cfg_busy = cfg_pend | (psel && (cur == XF_CFG));
  assign s_ready  = run & ~tx_full;

  always_ff @(posedge pclk or negedge rst_) begin
    if (!rst_)                acnt <= '0;
    else if (!penable)        acnt <= '0;
    else if (!pready)         acnt <= acnt + 8'd1;
  end

  // Address/data are loaded only on grant, so later cfg_req cannot disturb a transfer.
  always_ff @(posedge pclk or negedge rst_) begin
    if (!rst_) begin
      cur    <= XF_TX;
      paddr  <= '0;
      pwdata <= '0;
      pwrite <= 1'b0;
    end else if (grant) begin
      cur <= grant_kind;
      unique case (grant_kind)
        XF_CFG: begin
          paddr  <= CTRL_ADDR;
          pwdata <= cfg_data;
          pwrite <= 1'b1;
        end
        XF_RX: begin
          paddr  <= RX_ADDR;
          pwdata <= '0;
          pwrite <= 1'b0;
        end
        default: begin
          paddr  <= TX_ADDR;
          pwdata <= tx_data;
          pwrite <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge pclk or negedge rst_) begin
    if (!rst_) begin
      cfg_pend <= 1'b0;
      cfg_data <= '0;
    end else if (cfg_req) begin
      cfg_pend <= 1'b1;
      cfg_data <= cfg_ctrl;
    end else if (grant && (grant_kind == XF_CFG)) begin
      cfg_pend <= 1'b0;
    end
  end

  always_ff @(posedge pclk or negedge rst_) begin
    if (!rst_) begin
      tx_full <= 1'b0;
      tx_data <= '0;
    end else if (xfer_fin && (cur == XF_TX)) begin
      tx_full <= 1'b0;
    end else if (s_valid && s_ready) begin
      tx_full <= 1'b1;
      tx_data <= s_data;
    end
  end

  always_ff @(posedge pclk or negedge rst_) begin
    if (!rst_) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (xfer_done && !pslverr && (cur == XF_RX)) begin
      m_valid <= 1'b1;
      m_data  <= prdata;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

  always_ff @(posedge pclk or negedge rst_) begin
    if (!rst_)                             err <= 1'b0;
    else if (xfer_to || (xfer_done && pslverr)) err <= 1'b1;
  end

endmodule

// File: tb/tb_i2s_apb_master.sv
// Directed bench for i2s_apb_master with a small wait-state APB slave model.
module tb_i2s_apb_master;

  logic        pclk = 1'b0;
  logic        rst_;
  logic        cfg_req;
  logic [31:0] cfg_ctrl;
  logic        cfg_busy;
  logic        rx_en;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;
  logic        err;

  int          n_chk = 0;
  int          n_bad = 0;

  bit          never  = 1'b0;
  bit          slverr = 1'b0;
  int unsigned ws     = 0;
  logic [7:0]  acc_cnt = '0;

  logic [31:0] addr_q[$];
  logic [31:0] wdata_q[$];
  logic        wr_q[$];
  int          acc_seen = 0;

  always #5 pclk = ~pclk;

  i2s_apb_master #(
    .POLL_DIV(4),
    .TIMEOUT (16)
  ) dut (
    .pclk    (pclk),
    .rst_    (rst_),
    .cfg_req (cfg_req),
    .cfg_ctrl(cfg_ctrl),
    .cfg_busy(cfg_busy),
    .rx_en   (rx_en),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
    ,.err    (err)
  );

  // Slave inserts ws wait states; never holds pready low indefinitely.
  always @(posedge pclk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 8'd1;
    else                            acc_cnt <= '0;
  end
  assign pready  = psel & penable & ~never & (32'(acc_cnt) >= ws);
  assign pslverr = slverr;

  always @(negedge pclk) begin
    if (psel && !penable) begin
      addr_q.push_back(paddr);
      wdata_q.push_back(pwdata);
      wr_q.push_back(pwrite);
    end
    if (psel && penable) acc_seen = acc_seen + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int abase;
    rst_ = 1'b0; cfg_req = 1'b0; cfg_ctrl = '0; rx_en = 1'b0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0; prdata = '0;

    // reset state
    repeat (3) @(negedge pclk);
    chk("rst_psel",    32'(psel), 0);
    chk("rst_penable", 32'(penable), 0);
    chk("rst_pwrite",  32'(pwrite), 0);
    chk("rst_paddr",   paddr, 0);
    chk("rst_pwdata",  pwdata, 0);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data",  m_data, 0);
    chk("rst_busy",    32'(cfg_busy), 0);
    chk("rst_err",     32'(err), 0);
    rst_ = 1'b1;
    repeat (3) @(negedge pclk);
    chk("post_rst_s_ready", 32'(s_ready), 1);

    // config write, zero wait states
    cfg_ctrl = 32'h0000_1A85; cfg_req = 1'b1;
    @(negedge pclk); cfg_req = 1'b0;
    chk("cfg_busy_set", 32'(cfg_busy), 1);
    chk("cfg_idle_psel", 32'(psel), 0);
    @(negedge pclk);
    chk("cfg_setup", {29'd0, psel, penable, pwrite}, 32'b101);
    chk("cfg_setup_addr", paddr, 32'h4);
    chk("cfg_setup_data", pwdata, 32'h0000_1A85);
    @(negedge pclk);
    chk("cfg_access", {30'd0, psel, penable}, 32'b11);
    chk("cfg_access_addr", paddr, 32'h4);
    chk("cfg_access_data", pwdata, 32'h0000_1A85);
    @(negedge pclk);
    chk("cfg_busy_clr", 32'(cfg_busy), 0);
    chk("cfg_done_psel", 32'(psel), 0);

    // TX write with 3 wait states
    ws = 3;
    s_data = 32'hDEAD_BEEF; s_valid = 1'b1;
    @(negedge pclk); s_valid = 1'b0;
    chk("tx_s_ready_low", 32'(s_ready), 0);
    @(negedge pclk);
    chk("tx_setup", {29'd0, psel, penable, pwrite}, 32'b101);
    chk("tx_setup_data", pwdata, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      chk("tx_access", {penable, paddr[30:0]}, 32'h8000_0000);
      chk("tx_access_s_ready", 32'(s_ready), 0);
    end
    @(negedge pclk);
    chk("tx_s_ready_back", 32'(s_ready), 1);
    chk("tx_done_psel", 32'(psel), 0);

    // polled RX read with backpressure
    ws = 0; prdata = 32'h1234_5678;
    base = addr_q.size();
    rx_en = 1'b1;
    repeat (20) @(negedge pclk);
    chk("rx_reads_one", 32'(addr_q.size() - base), 1);
    if (addr_q.size() > base) begin
      chk("rx_addr", addr_q[base], 32'h8);
      chk("rx_pwrite", 32'(wr_q[base]), 0);
    end
    chk("rx_m_valid", 32'(m_valid), 1);
    chk("rx_m_data", m_data, 32'h1234_5678);
    prdata = 32'hCAFE_F00D;
    repeat (10) @(negedge pclk);
    chk("rx_hold_data", m_data, 32'h1234_5678);
    chk("rx_no_more_reads", 32'(addr_q.size() - base), 1);
    m_ready = 1'b1;
    @(negedge pclk); m_ready = 1'b0;
    repeat (10) @(negedge pclk);
    chk("rx_second_read", 32'(addr_q.size() - base), 2);
    chk("rx_second_data", m_data, 32'hCAFE_F00D);
    rx_en = 1'b0;
    @(negedge pclk); m_ready = 1'b1;
    @(negedge pclk); m_ready = 1'b0;
    @(negedge pclk);

    // arbitration: cfg, RX and TX all pending behind a stalled transfer
    never = 1'b1;
    base = addr_q.size();
    cfg_ctrl = 32'h0000_0011; cfg_req = 1'b1;
    @(negedge pclk); cfg_req = 1'b0;
    repeat (2) @(negedge pclk);
    cfg_ctrl = 32'h0000_0022; cfg_req = 1'b1;
    s_data = 32'hA5A5_0001; s_valid = 1'b1;
    rx_en = 1'b1;
    @(negedge pclk); cfg_req = 1'b0; s_valid = 1'b0;
    chk("inflight_addr", paddr, 32'h4);
    chk("inflight_data", pwdata, 32'h0000_0011);
    chk("inflight_penable", 32'(penable), 1);
    repeat (4) @(negedge pclk);
    never = 1'b0;
    repeat (20) @(negedge pclk);
    chk("arb_count", 32'(addr_q.size() - base), 4);
    if (addr_q.size() >= base + 4) begin
      chk("arb_0", addr_q[base], 32'h4);
      chk("arb_1", addr_q[base+1], 32'h4);
      chk("arb_2", addr_q[base+2], 32'h8);
      chk("arb_3", addr_q[base+3], 32'h0);
      chk("arb_cfg2_data", wdata_q[base+1], 32'h0000_0022);
      chk("arb_tx_data", wdata_q[base+3], 32'hA5A5_0001);
    end
    chk("arb_err", 32'(err), 0);
    rx_en = 1'b0;
    @(negedge pclk); m_ready = 1'b1;
    @(negedge pclk); m_ready = 1'b0;
    @(negedge pclk);

    // slave error on read
    slverr = 1'b1;
    base = addr_q.size();
    rx_en = 1'b1;
    repeat (8) @(negedge pclk);
    rx_en = 1'b0;
    repeat (6) @(negedge pclk);
    chk("slverr_read_seen", 32'(addr_q.size() > base), 1);
    chk("slverr_err", 32'(err), 1);
    chk("slverr_m_valid", 32'(m_valid), 0);
    slverr = 1'b0;

    // asynchronous reset during ACCESS
    never = 1'b1;
    s_data = 32'hBBBB_0002; s_valid = 1'b1;
    @(negedge pclk); s_valid = 1'b0;
    for (int i = 0; i < 10 && !penable; i++) @(negedge pclk);
    chk("arst_reached_access", 32'(penable), 1);
    #2 rst_ = 1'b0;
    #1;
    chk("arst_psel", 32'(psel), 0);
    chk("arst_penable", 32'(penable), 0);
    chk("arst_paddr_pwdata", paddr | pwdata, 0);
    chk("arst_err", 32'(err), 0);
    @(negedge pclk); rst_ = 1'b1;
    never = 1'b0;
    base = addr_q.size();
    repeat (4) @(negedge pclk);
    chk("arst_s_ready", 32'(s_ready), 1);
    chk("arst_no_replay", 32'(addr_q.size() - base), 0);

    // timeout: first transfer after reset, pready never arrives
    never = 1'b1;
    abase = acc_seen;
    s_data = 32'hC0DE_0003; s_valid = 1'b1;
    @(negedge pclk); s_valid = 1'b0;
    for (int i = 0; i < 10 && !psel; i++) @(negedge pclk);
    chk("to_first_psel", 32'(psel), 1);
    chk("to_first_is_setup", 32'(penable), 0);
    repeat (25) @(negedge pclk);
    chk("to_access_cycles", 32'(acc_seen - abase), 16);
    chk("to_err", 32'(err), 1);
    chk("to_idle", 32'(psel), 0);
    chk("to_tx_dropped", 32'(s_ready), 1);
    never = 1'b0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
